// File: rtl/carregador_memoria_ins.sv
// carregador_memoria_ins
//   Writer side of the instruction-memory interface. Takes a program as a byte
//   stream (LEN_LO, LEN_HI, then 4*N data bytes LSB first), packs little-endian
//   32-bit words and writes one per WRITE cycle at BASE_ADDR + 4*i. The CPU is
//   frozen through cpu_hold while loading and after a failed load.
//
//   Optional feature macro: CARREGADOR_CHECKSUM_EN
//     When defined, a trailing XOR checksum byte over all data bytes is
//     required (also for N==0, where it must be 0x00).
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   start              begin a load (honoured in IDLE, DONE, ERR)
//   rx_valid, rx_byte  byte stream in; rx_ready out, transfer = valid & ready
//   mem_we, mem_ads,   instruction-memory write port (64-bit byte address,
//   mem_din            data = {32'b0, word})
//   cpu_hold, busy     processor freeze / load in progress
//   done, error        load outcome, held until next start
//   word_count         words written in the current or last load
module carregador_memoria_ins #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [63:0] mem_ads,
    output logic [63:0] mem_din,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef CARREGADOR_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, next;
    logic [15:0] len_n;
    logic [23:0] word_q;     // first three bytes of the word being assembled
    logic [1:0]  byte_idx;
    logic        xfer;
    logic        start_ok;
    logic [15:0] len_full;
    logic        last_word;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0]  ck;
`endif

    assign xfer      = rx_valid & rx_ready;
    assign start_ok  = start & (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_full  = {rx_byte, len_n[7:0]};
    assign last_word = (16'(word_count + 16'd1) == len_n);

    // outputs decoded from state, so an async reset clears them immediately
    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: begin rx_ready = 1'b1; busy = 1'b1; end
`ifdef CARREGADOR_CHECKSUM_EN
            S_CHECK:                    begin rx_ready = 1'b1; busy = 1'b1; end
`endif
            S_WRITE:                    busy = 1'b1;
            default: ;
        endcase
    end

    assign cpu_hold = busy | (state == S_ERR);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);

    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) next = S_LEN_LO;
            S_LEN_LO: if (xfer) next = S_LEN_HI;
            S_LEN_HI: if (xfer) begin
                // length is validated before anything is written
                if (len_full == 16'd0)
`ifdef CARREGADOR_CHECKSUM_EN
                    next = S_CHECK;
`else
                    next = S_DONE;
`endif
                else if ({16'd0, len_full} > MAX_W) next = S_ERR;
                else                                next = S_DATA;
            end
            S_DATA: if (xfer && byte_idx == 2'd3) next = S_WRITE;
            S_WRITE: begin
                if (last_word)
`ifdef CARREGADOR_CHECKSUM_EN
                    next = S_CHECK;
`else
                    next = S_DONE;
`endif
                else next = S_DATA;
            end
`ifdef CARREGADOR_CHECKSUM_EN
            S_CHECK: if (xfer) next = (rx_byte == ck) ? S_DONE : S_ERR;
`endif
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_n      <= '0;
            word_q     <= '0;
            byte_idx   <= '0;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_ads    <= '0;
            mem_din    <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            ck         <= '0;
`endif
        end else begin
            state  <= next;
            mem_we <= (next == S_WRITE);
            if (start_ok) begin
                word_count <= '0;
                byte_idx   <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
                ck         <= '0;
`endif
            end
            if (state == S_LEN_LO && xfer) len_n[7:0]  <= rx_byte;
            if (state == S_LEN_HI && xfer) len_n[15:8] <= rx_byte;
            if (state == S_DATA && xfer) begin
                byte_idx <= byte_idx + 2'd1;
                // shifting right from the top leaves byte k at bits [8k+7:8k]
                word_q   <= {rx_byte, word_q[23:8]};
`ifdef CARREGADOR_CHECKSUM_EN
                ck       <= ck ^ rx_byte;
`endif
                if (byte_idx == 2'd3) begin
                    mem_din <= {32'd0, rx_byte, word_q};
                    mem_ads <= BASE_ADDR + {46'd0, word_count, 2'b00};
                end
            end
            if (state == S_WRITE) word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_carregador_memoria_ins.sv
// Directed bench for carregador_memoria_ins (BASE_ADDR=0, MAX_WORDS=64).
// Works in both builds; checksum bytes are sent only when
// CARREGADOR_CHECKSUM_EN is defined.
module tb_carregador_memoria_ins;

    logic        clk, rst_n, start, rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready, mem_we, cpu_hold, busy, done, error;
    logic [63:0] mem_ads, mem_din;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;
    int ready_in_write = 0;
    logic [63:0] wr_ads[$];
    logic [63:0] wr_din[$];

    carregador_memoria_ins #(.BASE_ADDR(64'd0), .MAX_WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_ads(mem_ads), .mem_din(mem_din), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write-port capture, sampled away from the active edge
    always @(negedge clk) begin
        if (mem_we) begin
            wr_ads.push_back(mem_ads);
            wr_din.push_back(mem_din);
            if (rx_ready) ready_in_write++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_byte  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) chk("xfer_timeout", {63'd0, ok}, 64'd1);
    endtask

    // last data byte just taken (WRITE cycle now): finish the load
    task automatic end_load(input logic [7:0] ck);
`ifdef CARREGADOR_CHECKSUM_EN
        send_byte(ck);
        rx_valid = 1'b0;
`else
        rx_valid = 1'b0;
        @(posedge clk); #1;
`endif
    endtask

    task automatic clear_log();
        wr_ads.delete();
        wr_din.delete();
        ready_in_write = 0;
    endtask

    initial begin
        logic [7:0] t2 [10];
        t2 = '{8'h02, 8'h00, 8'h83, 8'hB0, 8'h51, 8'h00, 8'h23, 8'h32, 8'h21, 8'h00};
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        #12;
        // reset state
        chk("rst_flags", {58'd0, mem_we, rx_ready, cpu_hold, busy, done, error}, 64'd0);
        chk("rst_ads", mem_ads, 64'd0);
        chk("rst_din", mem_din, 64'd0);
        chk("rst_wc", {48'd0, word_count}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T2: two words, valid held high
        clear_log();
        pulse_start();
        chk("t2_busy", {62'd0, busy, cpu_hold}, 64'd3);
        for (int i = 0; i < 10; i++) send_byte(t2[i]);
        chk("t2_write_cyc", {61'd0, mem_we, rx_ready, done}, 64'd4);
        end_load(8'h52);
        chk("t2_done", {62'd0, done, error}, 64'd2);
        chk("t2_wc", {48'd0, word_count}, 64'd2);
        chk("t2_hold", {62'd0, cpu_hold, busy}, 64'd0);
        chk("t2_nwr", 64'(wr_ads.size()), 64'd2);
        if (wr_ads.size() == 2) begin
            chk("t2_ads0", wr_ads[0], 64'd0);
            chk("t2_din0", wr_din[0], 64'h0000_0000_0051_B083);
            chk("t2_ads1", wr_ads[1], 64'd4);
            chk("t2_din1", wr_din[1], 64'h0000_0000_0021_3223);
        end

        // T3: same stream with random gaps; byte 6 is offered during WRITE
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (i != 6 && $urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            send_byte(t2[i]);
        end
        end_load(8'h52);
        chk("t3_done", {63'd0, done}, 64'd1);
        chk("t3_wc", {48'd0, word_count}, 64'd2);
        chk("t3_ready_in_write", 64'(ready_in_write), 64'd0);
        chk("t3_nwr", 64'(wr_ads.size()), 64'd2);
        if (wr_ads.size() == 2) begin
            chk("t3_din0", wr_din[0], 64'h0000_0000_0051_B083);
            chk("t3_ads1", wr_ads[1], 64'd4);
            chk("t3_din1", wr_din[1], 64'h0000_0000_0021_3223);
        end

`ifdef CARREGADOR_CHECKSUM_EN
        // T5: wrong checksum -> error, both words already written
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(t2[i]);
        send_byte(8'h53);
        rx_valid = 1'b0;
        chk("t5_err", {61'd0, error, done, cpu_hold}, 64'd5);
        chk("t5_nwr", 64'(wr_ads.size()), 64'd2);
`endif

        // T1: reset in the middle of DATA clears everything at once
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        rx_valid = 1'b0;
        chk("t1_mid_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_flags", {58'd0, mem_we, rx_ready, cpu_hold, busy, done, error}, 64'd0);
        chk("t1_ads", mem_ads, 64'd0);
        chk("t1_din", mem_din, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        end_load(8'h44);
        chk("t1_reload_done", {63'd0, done}, 64'd1);
        chk("t1_reload_nwr", 64'(wr_ads.size()), 64'd1);
        if (wr_ads.size() == 1) begin
            chk("t1_reload_ads", wr_ads[0], 64'd0);
            chk("t1_reload_din", wr_din[0], 64'h0000_0000_4433_2211);
        end

        // T4: empty program, then oversize length
        clear_log();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
`ifdef CARREGADOR_CHECKSUM_EN
        send_byte(8'h00);
`endif
        rx_valid = 1'b0;
        chk("t4_empty_done", {62'd0, done, cpu_hold}, 64'd2);
        chk("t4_empty_wc", {48'd0, word_count}, 64'd0);
        pulse_start();
        send_byte(8'h41); send_byte(8'h00);
        rx_valid = 1'b0;
        chk("t4_big_err", {60'd0, error, done, cpu_hold, busy}, 64'd10);
        @(posedge clk); #1;
        chk("t4_big_hold", {62'd0, cpu_hold, error}, 64'd3);
        chk("t4_nwr", 64'(wr_ads.size()), 64'd0);

        // T6: start mid-DATA ignored, start in DONE restarts
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        rx_valid = 1'b0;
        pulse_start();
        chk("t6_still_busy", {63'd0, busy}, 64'd1);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        end_load(8'h00);
        chk("t6_done", {62'd0, done, error}, 64'd2);
        chk("t6_wc", {48'd0, word_count}, 64'd1);
        chk("t6_nwr", 64'(wr_ads.size()), 64'd1);
        if (wr_ads.size() == 1) chk("t6_din", wr_din[0], 64'h0000_0000_DDCC_BBAA);
        pulse_start();
        chk("t6_restart", {47'd0, done, word_count}, 64'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        end_load(8'h44);
        chk("t6_reload_done", {47'd0, done, word_count}, 64'h1_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
